sig_mul_pipe: RTL and testbench

Pipelined, parametrised unsigned significand multiplier with valid/ready flow control. It multiplies two W-bit significands (hidden bit included) and returns the full 2W-bit product with a sideband tag and normalisation flags. It sits between operand unpacking and the normalise/round stage of the float MAC datapath. It replaces the fixed 11-bit, single-register multiplier and covers fp16, bf16 and fp32 significands.

---
 rtl/sig_mul_pkg.sv | 32 +++
 rtl/sig_mul_slot.sv | 48 ++++
 rtl/sig_mul_pipe.sv | 108 ++++++++++
 tb/tb_sig_mul_pipe.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sig_mul_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sig_mul_pkg
//  Description : Shared constants, helpers and slot metadata type for the
//                pipelined significand multiplier.
//  Revision    : 1.0 - initial release
// ============================================================================
package sig_mul_pkg;

    // Significand widths, hidden bit included
    localparam int SIG_W_FP16 = 11;
    localparam int SIG_W_BF16 = 8;
    localparam int SIG_W_FP32 = 24;

    // Widest sideband tag any instance may carry
    localparam int TAG_MAX_W  = 16;

    // Split point of the multiplier operand F[1]: low part gets the extra bit
    function automatic int sig_half(input int w);
        return (w + 1) / 2;
    endfunction

    // Per-slot control/sideband word. The tag field is sized for the widest
    // instance; narrower instances zero-extend into it.
    typedef struct packed {
        logic                 valid;
        logic [TAG_MAX_W-1:0] tag;
        logic                 zero;
    } slot_meta_t;

endpackage
`default_nettype wire

// File: rtl/sig_mul_slot.sv
`default_nettype none
// ============================================================================
//  Module      : sig_mul_slot
//  Description : One elastic register slot. Holds a valid bit, sideband and
//                a DATA_W payload; advances when empty or when the slot
//                downstream advances.
//  Revision    : 1.0 - initial release
// ============================================================================
module sig_mul_slot
    import sig_mul_pkg::*;
#(
    parameter int DATA_W = 22
)
(
    input  logic              CLK,
    input  logic              RSTn,
    input  slot_meta_t        i_meta,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_next_adv,
    output logic              o_adv,
    output slot_meta_t        o_meta,
    output logic [DATA_W-1:0] o_data
);

    slot_meta_t        r_meta;
    logic [DATA_W-1:0] r_data;

    assign o_adv  = !r_meta.valid || i_next_adv;
    assign o_meta = r_meta;
    assign o_data = r_data;

    // Capture on advance; payload only updates on a valid beat so bubbles keep the last value
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_meta <= '0;
            r_data <= '0;
        end else if (o_adv) begin
            r_meta.valid <= i_meta.valid;
            if (i_meta.valid) begin
                r_meta.tag  <= i_meta.tag;
                r_meta.zero <= i_meta.zero;
                r_data      <= i_data;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/sig_mul_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : sig_mul_pipe
//  Description : Pipelined unsigned W x W significand multiplier with
//                valid/ready flow control, sideband tag and ZERO/HI flags.
//                With two or more stages, slot 0 holds two partial products
//                and slot 1 holds their sum; further slots are delay.
//  Revision    : 1.0 - initial release
// ============================================================================
module sig_mul_pipe
    import sig_mul_pkg::*;
#(
    parameter int W      = 11,
    parameter int STAGES = 2,
    parameter int TAG_W  = 4
)
(
    input  logic                CLK,
    input  logic                RSTn,
    input  logic                IN_VALID,
    output logic                IN_READY,
    input  logic [1:0][W-1:0]   F,
    input  logic [TAG_W-1:0]    IN_TAG,
    output logic                OUT_VALID,
    input  logic                OUT_READY,
    output logic [2*W-1:0]      P,
    output logic [TAG_W-1:0]    OUT_TAG,
    output logic                HI,
    output logic                ZERO
);

    localparam int c_H    = sig_half(W);
    localparam int c_P_W  = 2 * W;
    localparam int c_LO_W = W + c_H;
    localparam int c_HI_W = 2 * W - c_H;

    // w_adv[k] = slot k advances; the extra top bit is the downstream consumer
    logic [STAGES:0]      w_adv;
    slot_meta_t           w_meta_q [STAGES];
    slot_meta_t           w_meta_0;
    logic [TAG_MAX_W-1:0] w_unused_tag;

    // Sideband entering slot 0: zero detect happens here and is carried along
    always_comb begin
        w_meta_0       = '0;
        w_meta_0.valid = IN_VALID;
        w_meta_0.tag   = TAG_MAX_W'(IN_TAG);
        w_meta_0.zero  = (F[0] == '0) || (F[1] == '0);
    end

    assign w_adv[STAGES] = OUT_READY;

    generate
        for (genvar k = 0; k < STAGES; k++) begin : g_slot
            // Slot 0 carries both partial products when the sum is deferred
            localparam int c_D_W = (k == 0 && STAGES > 1) ? (c_LO_W + c_HI_W) : c_P_W;

            logic [c_D_W-1:0] w_d;
            logic [c_D_W-1:0] w_q;
            slot_meta_t       w_meta_d;

            if (k == 0) begin : g_head
                assign w_meta_d = w_meta_0;
                if (STAGES == 1) begin : g_full
                    assign w_d = c_P_W'(F[0]) * c_P_W'(F[1]);
                end else begin : g_split
                    logic [c_LO_W-1:0] w_pp_lo;
                    logic [c_HI_W-1:0] w_pp_hi;
                    assign w_pp_lo = c_LO_W'(F[0]) * c_LO_W'(F[1][c_H-1:0]);
                    assign w_pp_hi = c_HI_W'(F[0]) * c_HI_W'(F[1][W-1:c_H]);
                    assign w_d     = {w_pp_hi, w_pp_lo};
                end
            end else if (k == 1) begin : g_sum
                // Recombine: exact in 2W bits, so no carry out is possible
                assign w_meta_d = w_meta_q[k-1];
                assign w_d = c_P_W'(g_slot[0].w_q[c_LO_W-1:0])
                           + (c_P_W'(g_slot[0].w_q[c_LO_W+c_HI_W-1:c_LO_W]) << c_H);
            end else begin : g_delay
                assign w_meta_d = w_meta_q[k-1];
                assign w_d      = g_slot[k-1].w_q;
            end

            sig_mul_slot #(
                .DATA_W     (c_D_W)
            ) u_slot (
                .CLK        (CLK),
                .RSTn       (RSTn),
                .i_meta     (w_meta_d),
                .i_data     (w_d),
                .i_next_adv (w_adv[k+1]),
                .o_adv      (w_adv[k]),
                .o_meta     (w_meta_q[k]),
                .o_data     (w_q)
            );
        end
    endgenerate

    // Ready is combinational through the advance chain from OUT_READY
    assign IN_READY     = w_adv[0];
    assign OUT_VALID    = w_meta_q[STAGES-1].valid;
    assign ZERO         = w_meta_q[STAGES-1].zero;
    assign w_unused_tag = w_meta_q[STAGES-1].tag;
    assign OUT_TAG      = w_unused_tag[TAG_W-1:0];
    assign P            = g_slot[STAGES-1].w_q;
    assign HI           = P[2*W-1];

endmodule
`default_nettype wire

// File: tb/tb_sig_mul_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sig_mul_pipe
//  Description : Directed and randomised checks of sig_mul_pipe at
//                (W=11,S=2), (W=8,S=1) and (W=24,S=3).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sig_mul_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstn;
    int   n_vec = 0;
    int   n_err = 0;

    // main instance: W=11, STAGES=2, TAG_W=4
    logic             m_iv, m_ir, m_ov, m_or, m_hi, m_zero;
    logic [1:0][10:0] m_f;
    logic [3:0]       m_itag, m_otag;
    logic [21:0]      m_p;

    // sweep instance a: W=8, STAGES=1
    logic             a_iv, a_ir, a_ov, a_or, a_hi, a_zero;
    logic [1:0][7:0]  a_f;
    logic [7:0]       a_itag, a_otag;
    logic [15:0]      a_p;

    // sweep instance b: W=24, STAGES=3
    logic             b_iv, b_ir, b_ov, b_or, b_hi, b_zero;
    logic [1:0][23:0] b_f;
    logic [7:0]       b_itag, b_otag;
    logic [47:0]      b_p;

    sig_mul_pipe #(.W(11), .STAGES(2), .TAG_W(4)) u_dut (
        .CLK(clk), .RSTn(rstn), .IN_VALID(m_iv), .IN_READY(m_ir), .F(m_f), .IN_TAG(m_itag),
        .OUT_VALID(m_ov), .OUT_READY(m_or), .P(m_p), .OUT_TAG(m_otag), .HI(m_hi), .ZERO(m_zero));

    sig_mul_pipe #(.W(8), .STAGES(1), .TAG_W(8)) u_dut_a (
        .CLK(clk), .RSTn(rstn), .IN_VALID(a_iv), .IN_READY(a_ir), .F(a_f), .IN_TAG(a_itag),
        .OUT_VALID(a_ov), .OUT_READY(a_or), .P(a_p), .OUT_TAG(a_otag), .HI(a_hi), .ZERO(a_zero));

    sig_mul_pipe #(.W(24), .STAGES(3), .TAG_W(8)) u_dut_b (
        .CLK(clk), .RSTn(rstn), .IN_VALID(b_iv), .IN_READY(b_ir), .F(b_f), .IN_TAG(b_itag),
        .OUT_VALID(b_ov), .OUT_READY(b_or), .P(b_p), .OUT_TAG(b_otag), .HI(b_hi), .ZERO(b_zero));

    longint     qa_p[$], qb_p[$];
    logic [7:0] qa_t[$], qb_t[$];
    logic       qa_z[$], qb_z[$];
    int         s, r, sa, ra, sb, rb, a_lat, b_lat;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] pick8();
        case ($urandom_range(0, 7))
            0:       return 8'h00;
            1:       return 8'hFF;
            default: return 8'($urandom);
        endcase
    endfunction

    function automatic logic [23:0] pick24();
        case ($urandom_range(0, 7))
            0:       return 24'h0;
            1:       return 24'hFFFFFF;
            default: return 24'($urandom);
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b0;
        m_iv = 1'b0; m_f = '0; m_itag = '0; m_or = 1'b1;
        a_iv = 1'b0; a_f = '0; a_itag = '0; a_or = 1'b1;
        b_iv = 1'b0; b_f = '0; b_itag = '0; b_or = 1'b1;

        // ---- reset state ----
        repeat (2) @(negedge clk);
        chk("rst_out_valid", m_ov, 0);
        chk("rst_p", m_p, 0);
        chk("rst_tag", m_otag, 0);
        chk("rst_hi", m_hi, 0);
        chk("rst_zero", m_zero, 0);
        chk("rst_in_ready", m_ir, 1);
        rstn = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", m_ir, 1);

        // ---- single pair, latency 2 ----
        tick(); m_iv = 1'b1; m_f[0] = 11'h400; m_f[1] = 11'h400; m_itag = 4'd3;
        @(negedge clk); chk("t1_in_ready", m_ir, 1);
        tick(); m_iv = 1'b0;
        @(negedge clk); chk("t1_not_yet", m_ov, 0);
        tick();
        @(negedge clk);
        chk("t1_valid", m_ov, 1);
        chk("t1_p", m_p, 22'h100000);
        chk("t1_hi", m_hi, 0);
        chk("t1_zero", m_zero, 0);
        chk("t1_tag", m_otag, 3);
        tick(); @(negedge clk); chk("t1_drained", m_ov, 0);

        // ---- back-to-back: max operands then zero operand ----
        tick(); m_iv = 1'b1; m_f[0] = 11'h7FF; m_f[1] = 11'h7FF; m_itag = 4'd5;
        tick(); m_f[0] = 11'h000; m_f[1] = 11'h5A3; m_itag = 4'd6;
        tick(); m_iv = 1'b0;
        @(negedge clk);
        chk("t2a_valid", m_ov, 1);
        chk("t2a_p", m_p, 22'h3FF001);
        chk("t2a_hi", m_hi, 1);
        chk("t2a_zero", m_zero, 0);
        chk("t2a_tag", m_otag, 5);
        tick(); @(negedge clk);
        chk("t2b_valid", m_ov, 1);
        chk("t2b_p", m_p, 0);
        chk("t2b_zero", m_zero, 1);
        chk("t2b_hi", m_hi, 0);
        chk("t2b_tag", m_otag, 6);
        tick(); @(negedge clk); chk("t2_drained", m_ov, 0);

        // ---- stream of 8 with a 5-cycle downstream stall ----
        s = 0; r = 0;
        for (int c = 0; c < 40 && r < 8; c++) begin
            tick();
            m_iv = (s < 8);
            m_f[0] = 11'(s + 1); m_f[1] = 11'h100; m_itag = 4'(s);
            m_or = !(c >= 3 && c <= 7);
            @(negedge clk);
            if (c >= 3 && c <= 7) begin
                chk("t3_stall_in_ready", m_ir, 0);
                chk("t3_stall_valid", m_ov, 1);
                chk("t3_stall_p", m_p, 22'h200);
                chk("t3_stall_tag", m_otag, 1);
            end
            if (c == 8) chk("t3_resume_in_ready", m_ir, 1);
            if (m_ov && m_or) begin
                chk("t3_tag", m_otag, r);
                chk("t3_p", m_p, (r + 1) * 256);
                r++;
            end
            if (m_iv && m_ir) s++;
        end
        m_iv = 1'b0;
        chk("t3_count", r, 8);
        tick(); @(negedge clk); chk("t3_empty", m_ov, 0);

        // ---- reset with two transactions in flight ----
        m_or = 1'b0;
        tick(); m_iv = 1'b1; m_f[0] = 11'd2; m_f[1] = 11'd3; m_itag = 4'd1;
        tick(); m_f[0] = 11'd4; m_f[1] = 11'd5; m_itag = 4'd2;
        tick(); m_iv = 1'b0;
        @(negedge clk); chk("t4_full_valid", m_ov, 1);
        rstn = 1'b0;
        #1;
        chk("t4_rst_valid", m_ov, 0);
        chk("t4_rst_p", m_p, 0);
        chk("t4_rst_in_ready", m_ir, 1);
        @(negedge clk);
        rstn = 1'b1;
        m_or = 1'b1;
        repeat (4) begin
            tick(); @(negedge clk); chk("t4_no_ghost", m_ov, 0);
        end
        tick(); m_iv = 1'b1; m_f[0] = 11'd3; m_f[1] = 11'd5; m_itag = 4'd9;
        tick(); m_iv = 1'b0;
        @(negedge clk); chk("t4_new_early", m_ov, 0);
        tick(); @(negedge clk);
        chk("t4_new_valid", m_ov, 1);
        chk("t4_new_p", m_p, 15);
        chk("t4_new_tag", m_otag, 9);

        // ---- latency of the sweep instances ----
        tick();
        a_iv = 1'b1; a_f[0] = 8'd7;     a_f[1] = 8'd9;     a_itag = 8'd0;
        b_iv = 1'b1; b_f[0] = 24'd1000; b_f[1] = 24'd3000; b_itag = 8'd0;
        tick(); a_iv = 1'b0; b_iv = 1'b0;
        a_lat = 0; b_lat = 0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (a_ov && a_lat == 0) begin a_lat = c; chk("a_lat_p", a_p, 63); end
            if (b_ov && b_lat == 0) begin b_lat = c; chk("b_lat_p", b_p, 3000000); end
            tick();
        end
        chk("a_latency", a_lat, 1);
        chk("b_latency", b_lat, 3);

        // ---- random sweep with random backpressure ----
        sa = 0; ra = 0; sb = 0; rb = 0;
        for (int c = 0; c < 20000 && (ra < 1000 || rb < 1000); c++) begin
            tick();
            a_iv = (sa < 1000) && ($urandom_range(0, 3) != 0);
            a_f[0] = pick8(); a_f[1] = pick8(); a_itag = 8'(sa);
            a_or = 1'($urandom_range(0, 1));
            b_iv = (sb < 1000) && ($urandom_range(0, 3) != 0);
            b_f[0] = pick24(); b_f[1] = pick24(); b_itag = 8'(sb);
            b_or = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (a_ov && a_or) begin
                if (qa_p.size() == 0) chk("a_spurious", a_ov, 0);
                else begin
                    chk("a_p", a_p, qa_p.pop_front());
                    chk("a_tag", a_otag, qa_t.pop_front());
                    chk("a_zero", a_zero, qa_z.pop_front());
                    ra++;
                end
            end
            if (b_ov && b_or) begin
                if (qb_p.size() == 0) chk("b_spurious", b_ov, 0);
                else begin
                    chk("b_p", b_p, qb_p.pop_front());
                    chk("b_tag", b_otag, qb_t.pop_front());
                    chk("b_zero", b_zero, qb_z.pop_front());
                    rb++;
                end
            end
            if (a_iv && a_ir) begin
                qa_p.push_back(longint'(a_f[0]) * longint'(a_f[1]));
                qa_t.push_back(a_itag);
                qa_z.push_back(a_f[0] == 8'h0 || a_f[1] == 8'h0);
                sa++;
            end
            if (b_iv && b_ir) begin
                qb_p.push_back(longint'(b_f[0]) * longint'(b_f[1]));
                qb_t.push_back(b_itag);
                qb_z.push_back(b_f[0] == 24'h0 || b_f[1] == 24'h0);
                sb++;
            end
        end
        a_iv = 1'b0; b_iv = 1'b0;
        chk("a_done", ra, 1000);
        chk("b_done", rb, 1000);
        chk("a_leftover", qa_p.size(), 0);
        chk("b_leftover", qb_p.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
